// File: rtl/neuron_config_mem_v2_pkg.sv
// Shared constants for the neuron configuration store: bank identifiers,
// header field layout, entry widths and the loader/sequencer state encodings.
package neuron_cfg_pkg;

  // Header layout: bank id in the top three bits, start address and count below.
  localparam int HDR_BANK_W   = 3;
  localparam int HDR_FIELD_W  = 16;
  localparam int HDR_ADDR_LSB = 16;
  localparam int HDR_CNT_LSB  = 0;

  // Bank ids 6 and 7 are ignored by the loader.
  localparam int NUM_BANKS = 6;
  localparam logic [HDR_BANK_W-1:0] BANK_A      = 3'd0;
  localparam logic [HDR_BANK_W-1:0] BANK_B      = 3'd1;
  localparam logic [HDR_BANK_W-1:0] BANK_FANCNT = 3'd2;
  localparam logic [HDR_BANK_W-1:0] BANK_AER    = 3'd3;
  localparam logic [HDR_BANK_W-1:0] BANK_SCALE  = 3'd4;
  localparam logic [HDR_BANK_W-1:0] BANK_CORE   = 3'd5;

  // Entry widths of the two neuron banks for a given parameter set.
  function automatic int entry_a_w(input int stdp_win_w, input int dsize);
    return 2 * stdp_win_w + 2 * dsize + 1;
  endfunction

  function automatic int entry_b_w(input int dsize);
    return 2 + 3 * dsize;
  endfunction

  // Default entry widths (STDP_WIN_W=8, DSIZE=16).
  localparam int CFG_A_W = entry_a_w(8, 16);
  localparam int CFG_B_W = entry_b_w(16);

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_DATA = 2'd1
  } ld_state_t;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_CNT  = 2'd1,
    SQ_EMIT = 2'd2
  } sq_state_t;

endpackage

// File: rtl/neuron_config_mem_v2_if.sv
// Streaming handshakes of the configuration store: config ingress, spike
// input and multicast AER output. The store itself is the slave side.
interface neuron_config_mem_v2_if #(
  parameter int CFG_W  = 64,
  parameter int NURN_W = 8,
  parameter int AER_W  = 32
);
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [CFG_W-1:0]  cfg_data_i;
  logic              cfg_busy_o;

  logic              spk_valid_i;
  logic [NURN_W-1:0] spk_nid_i;
  logic              spk_ready_o;

  logic              aer_valid_o;
  logic [AER_W-1:0]  aer_data_o;
  logic              aer_last_o;
  logic              aer_ready_i;

  modport slave (
    input  cfg_valid_i, cfg_data_i, spk_valid_i, spk_nid_i, aer_ready_i,
    output cfg_ready_o, cfg_busy_o, spk_ready_o, aer_valid_o, aer_data_o, aer_last_o
  );

  modport master (
    output cfg_valid_i, cfg_data_i, spk_valid_i, spk_nid_i, aer_ready_i,
    input  cfg_ready_o, cfg_busy_o, spk_ready_o, aer_valid_o, aer_data_o, aer_last_o
  );

endinterface

// File: rtl/neuron_config_mem_v2_loader.sv
// Streaming config loader: decodes a header word, then turns the next N
// accepted payload words into per-bank write strobes at incrementing addresses.
//
// state   | meaning
// LD_IDLE | waiting for a header; bad bank or N=0 headers are consumed here
// LD_DATA | mid-burst, each accepted word writes bank[addr] and advances addr
module cfg_stream_loader
  import neuron_cfg_pkg::*;
#(
  parameter int CFG_W = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cfg_valid_i,
  input  logic                   cfg_ready_i,
  input  logic [CFG_W-1:0]       cfg_data_i,
  output logic                   busy_o,
  output logic [NUM_BANKS-1:0]   wr_en_o,
  output logic [HDR_FIELD_W-1:0] wr_addr_o,
  output logic [CFG_W-1:0]       wr_data_o
);

  ld_state_t               state_q;
  logic [HDR_BANK_W-1:0]   bank_q;
  logic [HDR_FIELD_W-1:0]  addr_q;
  logic [HDR_FIELD_W-1:0]  left_q;

  logic                    accept;
  logic [HDR_BANK_W-1:0]   hdr_bank;
  logic [HDR_FIELD_W-1:0]  hdr_addr;
  logic [HDR_FIELD_W-1:0]  hdr_cnt;
  logic                    hdr_ok;

  assign accept   = cfg_valid_i & cfg_ready_i;
  assign hdr_bank = cfg_data_i[CFG_W-1 -: HDR_BANK_W];
  assign hdr_addr = cfg_data_i[HDR_ADDR_LSB +: HDR_FIELD_W];
  assign hdr_cnt  = cfg_data_i[HDR_CNT_LSB +: HDR_FIELD_W];
  assign hdr_ok   = (hdr_bank <= BANK_CORE) && (hdr_cnt != '0);

  assign wr_addr_o = addr_q;
  assign wr_data_o = cfg_data_i;

  // One-hot write strobe for the bank selected by the current burst.
  always_comb begin
    wr_en_o = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      wr_en_o[i] = (state_q == LD_DATA) && accept && (bank_q == HDR_BANK_W'(i));
    end
  end

  // Loader FSM; the remaining-word count is a down-counter ending at 1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= LD_IDLE;
      bank_q  <= '0;
      addr_q  <= '0;
      left_q  <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (accept && hdr_ok) begin
            bank_q  <= hdr_bank;
            addr_q  <= hdr_addr;
            left_q  <= hdr_cnt;
            busy_o  <= 1'b1;
            state_q <= LD_DATA;
          end
        end
        LD_DATA: begin
          if (accept) begin
            addr_q <= addr_q + 16'd1;
            left_q <= left_q - 16'd1;
            if (left_q == 16'd1) begin
              busy_o  <= 1'b0;
              state_q <= LD_IDLE;
            end
          end
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/neuron_config_mem_v2.sv
// Per-core neuron configuration store: streaming-loaded banks A/B, axon
// scaling, fan-out counts and AER targets, plus a multicast AER sequencer.
//
// state   | meaning
// SQ_IDLE | accepting a spike; fan-out count of the spiking neuron is read
// SQ_CNT  | clamped count available; zero ends the burst with no output
// SQ_EMIT | valid low: fetch word k; valid high: hold until the router takes it
module neuron_config_mem_v2
  import neuron_cfg_pkg::*;
#(
  parameter int NUM_NURNS  = 256,
  parameter int NURN_W     = 8,
  parameter int NUM_AXONS  = 256,
  parameter int AXON_W     = 8,
  parameter int DSIZE      = 16,
  parameter int STDP_WIN_W = 8,
  parameter int AER_W      = 32,
  parameter int MAX_FANOUT = 4,
  parameter int FAN_W      = 3,
  parameter int CFG_W      = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  neuron_config_mem_v2_if.slave             bus,
  input  logic                              rd_a_en_i,
  input  logic [NURN_W-1:0]                 rd_a_addr_i,
  output logic [2*STDP_WIN_W+2*DSIZE:0]     rd_a_data_o,
  input  logic                              rd_b_en_i,
  input  logic [NURN_W-1:0]                 rd_b_addr_i,
  output logic [3*DSIZE+1:0]                rd_b_data_o,
  input  logic [AXON_W-1:0]                 scl_addr_i,
  output logic [1:0]                        scl_data_o,
  output logic [NURN_W-1:0]                 num_nurn_o,
  output logic [AXON_W-1:0]                 num_axon_o
);

  localparam int A_W   = entry_a_w(STDP_WIN_W, DSIZE);
  localparam int B_W   = entry_b_w(DSIZE);
  localparam int AER_N = NUM_NURNS * MAX_FANOUT;
  localparam int IDX_W = NURN_W + $clog2(MAX_FANOUT);

  logic [A_W-1:0]   mem_a   [NUM_NURNS];
  logic [B_W-1:0]   mem_b   [NUM_NURNS];
  logic [FAN_W-1:0] mem_fan [NUM_NURNS];
  logic [AER_W-1:0] mem_aer [AER_N];
  logic [1:0]       mem_scl [NUM_AXONS];

  logic                   ld_busy;
  logic [NUM_BANKS-1:0]   wr_en;
  logic [HDR_FIELD_W-1:0] wr_addr;
  logic [CFG_W-1:0]       wr_data;
  logic                   unused_wr_bits;

  sq_state_t        sq_q;
  logic [NURN_W-1:0] nid_q;
  logic [FAN_W-1:0]  fan_q;
  logic [FAN_W-1:0]  cnt_q;
  logic [FAN_W-1:0]  k_q;
  logic [FAN_W-1:0]  fan_clamped;
  logic [IDX_W-1:0]  aer_idx;
  logic              aer_valid_q;
  logic              aer_last_q;
  logic [AER_W-1:0]  aer_data_q;
  logic              cfg_ready;
  logic              spk_ready;

  // Config and spikes share the store: a pending header blocks spikes, and an
  // active AER burst blocks config.
  assign cfg_ready = (sq_q == SQ_IDLE);
  assign spk_ready = (sq_q == SQ_IDLE) && !ld_busy && !bus.cfg_valid_i;

  assign bus.cfg_ready_o = cfg_ready;
  assign bus.cfg_busy_o  = ld_busy;
  assign bus.spk_ready_o = spk_ready;
  assign bus.aer_valid_o = aer_valid_q;
  assign bus.aer_data_o  = aer_data_q;
  assign bus.aer_last_o  = aer_last_q;

  // Upper payload and address bits beyond each bank's width are dropped.
  assign unused_wr_bits = ^{wr_addr, wr_data};

  cfg_stream_loader #(
    .CFG_W (CFG_W)
  ) u_loader (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cfg_valid_i (bus.cfg_valid_i),
    .cfg_ready_i (cfg_ready),
    .cfg_data_i  (bus.cfg_data_i),
    .busy_o      (ld_busy),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  // Bank writes; addresses wrap by truncation to each bank's index width.
  always_ff @(posedge clk_i) begin
    if (wr_en[BANK_A])      mem_a[wr_addr[NURN_W-1:0]]   <= wr_data[A_W-1:0];
    if (wr_en[BANK_B])      mem_b[wr_addr[NURN_W-1:0]]   <= wr_data[B_W-1:0];
    if (wr_en[BANK_FANCNT]) mem_fan[wr_addr[NURN_W-1:0]] <= wr_data[FAN_W-1:0];
    if (wr_en[BANK_AER])    mem_aer[wr_addr[IDX_W-1:0]]  <= wr_data[AER_W-1:0];
    if (wr_en[BANK_SCALE])  mem_scl[wr_addr[AXON_W-1:0]] <= wr_data[1:0];
  end

  // Core size registers; the header address is irrelevant for this bank.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      num_nurn_o <= '0;
      num_axon_o <= '0;
    end else if (wr_en[BANK_CORE]) begin
      num_nurn_o <= wr_data[NURN_W+AXON_W-1:AXON_W];
      num_axon_o <= wr_data[AXON_W-1:0];
    end
  end

  // Registered read ports; A/B hold their last value while not enabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_a_data_o <= '0;
      rd_b_data_o <= '0;
      scl_data_o  <= '0;
    end else begin
      if (rd_a_en_i) rd_a_data_o <= mem_a[rd_a_addr_i];
      if (rd_b_en_i) rd_b_data_o <= mem_b[rd_b_addr_i];
      scl_data_o <= mem_scl[scl_addr_i];
    end
  end

  assign fan_clamped = (fan_q > FAN_W'(MAX_FANOUT)) ? FAN_W'(MAX_FANOUT) : fan_q;
  assign aer_idx     = IDX_W'(nid_q) * IDX_W'(MAX_FANOUT) + IDX_W'(k_q);

  // Multicast sequencer; a bubble cycle separates consecutive AER words.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sq_q        <= SQ_IDLE;
      nid_q       <= '0;
      fan_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      aer_valid_q <= 1'b0;
      aer_last_q  <= 1'b0;
      aer_data_q  <= '0;
    end else begin
      case (sq_q)
        SQ_IDLE: begin
          if (bus.spk_valid_i && spk_ready) begin
            nid_q <= bus.spk_nid_i;
            fan_q <= mem_fan[bus.spk_nid_i];
            sq_q  <= SQ_CNT;
          end
        end
        SQ_CNT: begin
          k_q   <= '0;
          cnt_q <= fan_clamped;
          sq_q  <= (fan_clamped == '0) ? SQ_IDLE : SQ_EMIT;
        end
        SQ_EMIT: begin
          if (!aer_valid_q) begin
            aer_data_q  <= mem_aer[aer_idx];
            aer_valid_q <= 1'b1;
            aer_last_q  <= ((k_q + FAN_W'(1)) == cnt_q);
          end else if (bus.aer_ready_i) begin
            aer_valid_q <= 1'b0;
            aer_last_q  <= 1'b0;
            if (aer_last_q) sq_q <= SQ_IDLE;
            else            k_q  <= k_q + FAN_W'(1);
          end
        end
        default: begin
          aer_valid_q <= 1'b0;
          aer_last_q  <= 1'b0;
          sq_q        <= SQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_config_mem_v2.sv
// Directed bench for neuron_config_mem_v2: loader bursts, read ports,
// multicast AER bursts with backpressure, and asynchronous reset mid-burst.
module tb_neuron_config_mem_v2;
  import neuron_cfg_pkg::*;

  localparam int CFG_W  = 64;
  localparam int NURN_W = 8;
  localparam int AXON_W = 8;
  localparam int AER_W  = 32;
  localparam int A_W    = 49;
  localparam int B_W    = 50;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  neuron_config_mem_v2_if #(.CFG_W(CFG_W), .NURN_W(NURN_W), .AER_W(AER_W)) bus ();

  logic              rd_a_en_i;
  logic [NURN_W-1:0] rd_a_addr_i;
  logic [A_W-1:0]    rd_a_data_o;
  logic              rd_b_en_i;
  logic [NURN_W-1:0] rd_b_addr_i;
  logic [B_W-1:0]    rd_b_data_o;
  logic [AXON_W-1:0] scl_addr_i;
  logic [1:0]        scl_data_o;
  logic [NURN_W-1:0] num_nurn_o;
  logic [AXON_W-1:0] num_axon_o;

  neuron_config_mem_v2 dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .bus         (bus),
    .rd_a_en_i   (rd_a_en_i),
    .rd_a_addr_i (rd_a_addr_i),
    .rd_a_data_o (rd_a_data_o),
    .rd_b_en_i   (rd_b_en_i),
    .rd_b_addr_i (rd_b_addr_i),
    .rd_b_data_o (rd_b_data_o),
    .scl_addr_i  (scl_addr_i),
    .scl_data_o  (scl_data_o),
    .num_nurn_o  (num_nurn_o),
    .num_axon_o  (num_axon_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [AER_W-1:0] got_data [8];
  logic             got_last [8];
  int               n_words;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [2:0] bank, input logic [15:0] addr,
                                      input logic [15:0] n);
    return {bank, 29'd0, addr, n};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_send(input logic [63:0] w);
    int n = 0;
    bus.cfg_data_i  = w;
    bus.cfg_valid_i = 1'b1;
    while (!bus.cfg_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_val("cfg_ready_timeout", 64'(bus.cfg_ready_o), 64'd1);
    tick();
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic spk_send(input logic [7:0] nid);
    int n = 0;
    bus.spk_nid_i   = nid;
    bus.spk_valid_i = 1'b1;
    while (!bus.spk_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_val("spk_ready_timeout", 64'(bus.spk_ready_o), 64'd1);
    tick();
    bus.spk_valid_i = 1'b0;
  endtask

  task automatic read_a(input logic [7:0] a);
    rd_a_addr_i = a;
    rd_a_en_i   = 1'b1;
    tick();
    rd_a_en_i = 1'b0;
  endtask

  task automatic read_scl(input logic [7:0] a);
    scl_addr_i = a;
    tick();
  endtask

  // Records every AER word up to and including the one flagged last; when a
  // word's index equals stall_idx, ready is held low for five cycles first.
  task automatic collect(input int stall_idx, output int nw);
    int guard = 0;
    int idx = 0;
    logic done = 1'b0;
    logic [AER_W-1:0] hold;
    bus.aer_ready_i = 1'b1;
    while (!done && guard < 60 && idx < 8) begin
      if (bus.aer_valid_o) begin
        if (idx == stall_idx) begin
          bus.aer_ready_i = 1'b0;
          hold = bus.aer_data_o;
          for (int s = 0; s < 5; s++) begin
            tick();
            check_val("stall_valid", 64'(bus.aer_valid_o), 64'd1);
            check_val("stall_data", 64'(bus.aer_data_o), 64'(hold));
          end
          bus.aer_ready_i = 1'b1;
        end
        got_data[idx] = bus.aer_data_o;
        got_last[idx] = bus.aer_last_o;
        idx++;
        if (bus.aer_last_o) done = 1'b1;
      end
      tick();
      guard++;
    end
    check_val("aer_burst_done", 64'(done), 64'd1);
    nw = idx;
  endtask

  task automatic check_abc(input string tag);
    check_val({tag, "_count"}, 64'(n_words), 64'd3);
    check_val({tag, "_w0"}, 64'(got_data[0]), 64'hA);
    check_val({tag, "_w1"}, 64'(got_data[1]), 64'hB);
    check_val({tag, "_w2"}, 64'(got_data[2]), 64'hC);
    check_val({tag, "_last"}, 64'({got_last[0], got_last[1], got_last[2]}), 64'b001);
    check_val({tag, "_spk_ready"}, 64'(bus.spk_ready_o), 64'd1);
    check_val({tag, "_valid_low"}, 64'(bus.aer_valid_o), 64'd0);
  endtask

  initial begin
    int vcount;
    int guard;
    bus.cfg_valid_i = 1'b0;
    bus.cfg_data_i  = '0;
    bus.spk_valid_i = 1'b0;
    bus.spk_nid_i   = '0;
    bus.aer_ready_i = 1'b1;
    rd_a_en_i   = 1'b0;
    rd_a_addr_i = '0;
    rd_b_en_i   = 1'b0;
    rd_b_addr_i = '0;
    scl_addr_i  = '0;

    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    check_val("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    check_val("rst_spk_ready", 64'(bus.spk_ready_o), 64'd1);
    check_val("rst_aer_valid", 64'(bus.aer_valid_o), 64'd0);
    check_val("rst_cfg_busy", 64'(bus.cfg_busy_o), 64'd0);
    check_val("rst_num_nurn", 64'(num_nurn_o), 64'd0);
    check_val("rst_rd_a", 64'(rd_a_data_o), 64'd0);

    // Bank A burst at 5..7 with a neighbour at 8 that must survive.
    cfg_send(hdr(BANK_A, 16'd8, 16'd1));
    cfg_send(64'h99);
    cfg_send(hdr(BANK_A, 16'd5, 16'd3));
    check_val("a_busy_mid", 64'(bus.cfg_busy_o), 64'd1);
    cfg_send(64'h11);
    cfg_send(64'h22);
    cfg_send(64'h33);
    check_val("a_busy_end", 64'(bus.cfg_busy_o), 64'd0);
    read_a(8'd6);
    check_val("a_rd6", 64'(rd_a_data_o), 64'h22);
    rd_a_addr_i = 8'd5;
    tick();
    check_val("a_hold", 64'(rd_a_data_o), 64'h22);
    read_a(8'd5);
    check_val("a_rd5", 64'(rd_a_data_o), 64'h11);
    read_a(8'd7);
    check_val("a_rd7", 64'(rd_a_data_o), 64'h33);
    read_a(8'd8);
    check_val("a_rd8", 64'(rd_a_data_o), 64'h99);

    // Read of the address written in the same cycle sees the old entry.
    cfg_send(hdr(BANK_A, 16'd8, 16'd1));
    bus.cfg_data_i  = 64'h77;
    bus.cfg_valid_i = 1'b1;
    rd_a_addr_i = 8'd8;
    rd_a_en_i   = 1'b1;
    tick();
    bus.cfg_valid_i = 1'b0;
    rd_a_en_i = 1'b0;
    check_val("rdw_old", 64'(rd_a_data_o), 64'h99);
    read_a(8'd8);
    check_val("rdw_new", 64'(rd_a_data_o), 64'h77);

    // Bank B and core size.
    cfg_send(hdr(BANK_B, 16'd10, 16'd1));
    cfg_send(64'h0003_ABCD_1234_5678);
    rd_b_addr_i = 8'd10;
    rd_b_en_i   = 1'b1;
    tick();
    rd_b_en_i = 1'b0;
    check_val("b_rd10", 64'(rd_b_data_o), 64'h0003_ABCD_1234_5678);
    cfg_send(hdr(BANK_CORE, 16'd77, 16'd1));
    cfg_send(64'h0000_0000_0000_C864);
    check_val("core_nurn", 64'(num_nurn_o), 64'd200);
    check_val("core_axon", 64'(num_axon_o), 64'd100);

    // Fan-out of three for neuron 7, targets 0xA/0xB/0xC at 28..30.
    cfg_send(hdr(BANK_FANCNT, 16'd7, 16'd1));
    cfg_send(64'd3);
    cfg_send(hdr(BANK_AER, 16'd28, 16'd3));
    cfg_send(64'hA);
    cfg_send(64'hB);
    cfg_send(64'hC);
    spk_send(8'd7);
    collect(-1, n_words);
    check_abc("mc");
    spk_send(8'd7);
    collect(1, n_words);
    check_abc("stall");

    // Zero fan-out gives nothing; seven is clamped to four.
    cfg_send(hdr(BANK_FANCNT, 16'd3, 16'd2));
    cfg_send(64'd0);
    cfg_send(64'd7);
    cfg_send(hdr(BANK_AER, 16'd16, 16'd4));
    cfg_send(64'h40);
    cfg_send(64'h41);
    cfg_send(64'h42);
    cfg_send(64'h43);
    spk_send(8'd3);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.aer_valid_o) vcount++;
      tick();
    end
    check_val("zero_fan_valid", 64'(vcount), 64'd0);
    check_val("zero_fan_ready", 64'(bus.spk_ready_o), 64'd1);
    spk_send(8'd4);
    collect(-1, n_words);
    check_val("clamp_count", 64'(n_words), 64'd4);
    check_val("clamp_w0", 64'(got_data[0]), 64'h40);
    check_val("clamp_w3", 64'(got_data[3]), 64'h43);
    check_val("clamp_last", 64'({got_last[0], got_last[1], got_last[2], got_last[3]}), 64'b0001);

    // Header and spike in the same cycle: the header is taken.
    bus.cfg_data_i  = hdr(BANK_A, 16'd20, 16'd1);
    bus.cfg_valid_i = 1'b1;
    bus.spk_nid_i   = 8'd4;
    bus.spk_valid_i = 1'b1;
    #1;
    check_val("contend_spk_ready", 64'(bus.spk_ready_o), 64'd0);
    tick();
    bus.cfg_valid_i = 1'b0;
    check_val("contend_busy", 64'(bus.cfg_busy_o), 64'd1);
    check_val("contend_spk_blocked", 64'(bus.spk_ready_o), 64'd0);
    bus.spk_valid_i = 1'b0;
    cfg_send(64'h5);

    // Scaling bank wrap, N=0 and ignored-bank headers.
    cfg_send(hdr(BANK_SCALE, 16'd1, 16'd1));
    cfg_send(64'd3);
    cfg_send(hdr(BANK_SCALE, 16'd255, 16'd2));
    bus.spk_nid_i   = 8'd7;
    bus.spk_valid_i = 1'b1;
    #1;
    check_val("burst_spk_ready", 64'(bus.spk_ready_o), 64'd0);
    bus.spk_valid_i = 1'b0;
    cfg_send(64'd1);
    cfg_send(64'd2);
    cfg_send(hdr(BANK_SCALE, 16'd1, 16'd0));
    check_val("n0_busy", 64'(bus.cfg_busy_o), 64'd0);
    cfg_send(hdr(3'd7, 16'd1, 16'd1));
    check_val("ign_busy", 64'(bus.cfg_busy_o), 64'd0);
    read_scl(8'd255);
    check_val("scl_255", 64'(scl_data_o), 64'd1);
    read_scl(8'd0);
    check_val("scl_wrap0", 64'(scl_data_o), 64'd2);
    read_scl(8'd1);
    check_val("scl_untouched", 64'(scl_data_o), 64'd3);

    // Reset in the middle of a bank A burst keeps the partial write.
    cfg_send(hdr(BANK_A, 16'd30, 16'd3));
    cfg_send(64'h55);
    #1 rst_n_i = 1'b0;
    #1;
    check_val("rd_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    check_val("rd_busy", 64'(bus.cfg_busy_o), 64'd0);
    check_val("rd_num_nurn", 64'(num_nurn_o), 64'd0);
    tick();
    rst_n_i = 1'b1;
    read_a(8'd30);
    check_val("rd_partial", 64'(rd_a_data_o), 64'h55);
    cfg_send(hdr(BANK_A, 16'd31, 16'd1));
    cfg_send(64'h66);
    read_a(8'd31);
    check_val("rd_after", 64'(rd_a_data_o), 64'h66);

    // Reset while a word is waiting on the router.
    bus.aer_ready_i = 1'b0;
    spk_send(8'd7);
    guard = 0;
    while (!bus.aer_valid_o && guard < 20) begin
      tick();
      guard++;
    end
    check_val("re_emit_reached", 64'(bus.aer_valid_o), 64'd1);
    #1 rst_n_i = 1'b0;
    #1;
    check_val("re_aer_valid", 64'(bus.aer_valid_o), 64'd0);
    check_val("re_aer_last", 64'(bus.aer_last_o), 64'd0);
    check_val("re_spk_ready", 64'(bus.spk_ready_o), 64'd1);
    tick();
    rst_n_i = 1'b1;
    bus.aer_ready_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
